// File: rtl/serial_audio_frame_sequencer.sv
// Stereo frame sequencer: takes one L/R frame per source handshake and issues it to the
// serial audio encoder as a left word then a right word, with optional silence fill and stats.
module serial_audio_frame_sequencer #(
  parameter int data_width  = 32,
  parameter int count_width = 16
) (
  input  logic                   sclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   zero_fill,
  input  logic                   clear_stats,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [data_width-1:0]  s_left,
  input  logic [data_width-1:0]  s_right,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_is_left,
  output logic [data_width-1:0]  o_data,
  input  logic                   enc_underrun,
  output logic                   running,
  output logic [count_width-1:0] underrun_count,
  output logic [count_width-1:0] zero_frame_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

  localparam logic [count_width-1:0] cnt_one = {{(count_width-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [data_width-1:0]  left_q, left_d, right_q, right_d;
  logic [data_width-1:0]  o_data_q, o_data_d;
  logic                   o_valid_q, o_valid_d;
  logic                   o_is_left_q, o_is_left_d;
  logic                   running_q, running_d;
  logic                   und_prev_q, und_prev_d;
  logic [count_width-1:0] urc_q, urc_d, zfc_q, zfc_d;
  logic                   word_xfer, frame_xfer, load_frame, load_zero, go_idle;

  // Next-state, next-output and statistics computation.
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    o_data_d    = o_data_q;
    o_valid_d   = o_valid_q;
    o_is_left_d = o_is_left_q;
    load_frame  = 1'b0;
    load_zero   = 1'b0;
    go_idle     = 1'b0;

    case (state_q)
      IDLE:    s_ready = enable;
      RIGHT:   s_ready = enable && o_ready;
      default: s_ready = 1'b0;
    endcase

    word_xfer  = o_valid_q && o_ready;
    frame_xfer = s_valid && s_ready;

    case (state_q)
      IDLE: begin
        if (frame_xfer) begin
          load_frame = 1'b1;
        end else if (enable && zero_fill && !s_valid) begin
          load_zero = 1'b1;
        end else begin
          go_idle = 1'b0;
        end
      end
      LEFT: begin
        if (word_xfer) begin
          state_d     = RIGHT;
          o_is_left_d = 1'b0;
          o_data_d    = right_q;
        end else begin
          state_d = LEFT;
        end
      end
      RIGHT: begin
        if (word_xfer && frame_xfer) begin
          load_frame = 1'b1;
        end else if (word_xfer && enable && zero_fill) begin
          load_zero = 1'b1;
        end else if (word_xfer) begin
          go_idle = 1'b1;
        end else begin
          state_d = RIGHT;
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    // A new frame (real or silent) always restarts on the left word.
    if (load_frame || load_zero) begin
      state_d     = LEFT;
      left_d      = load_frame ? s_left  : '0;
      right_d     = load_frame ? s_right : '0;
      o_data_d    = load_frame ? s_left  : '0;
      o_valid_d   = 1'b1;
      o_is_left_d = 1'b1;
    end else if (go_idle) begin
      state_d     = IDLE;
      o_valid_d   = 1'b0;
      o_is_left_d = 1'b1;
    end else begin
      running_d = 1'b0;
    end

    running_d  = (state_d != IDLE);
    und_prev_d = enc_underrun;

    if (clear_stats) begin
      urc_d = '0;
    end else if (enc_underrun && !und_prev_q && running_q && (urc_q != '1)) begin
      urc_d = urc_q + cnt_one;
    end else begin
      urc_d = urc_q;
    end

    if (clear_stats) begin
      zfc_d = '0;
    end else if (load_zero && (zfc_q != '1)) begin
      zfc_d = zfc_q + cnt_one;
    end else begin
      zfc_d = zfc_q;
    end
  end

  // State, held frame, registered encoder outputs and counters.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q     <= IDLE;
      left_q      <= '0;
      right_q     <= '0;
      o_data_q    <= '0;
      o_valid_q   <= 1'b0;
      o_is_left_q <= 1'b1;
      running_q   <= 1'b0;
      und_prev_q  <= 1'b1;
      urc_q       <= '0;
      zfc_q       <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      o_data_q    <= o_data_d;
      o_valid_q   <= o_valid_d;
      o_is_left_q <= o_is_left_d;
      running_q   <= running_d;
      und_prev_q  <= und_prev_d;
      urc_q       <= urc_d;
      zfc_q       <= zfc_d;
    end
  end

  assign o_valid          = o_valid_q;
  assign o_is_left        = o_is_left_q;
  assign o_data           = o_data_q;
  assign running          = running_q;
  assign underrun_count   = urc_q;
  assign zero_frame_count = zfc_q;

endmodule

// File: tb/tb_serial_audio_frame_sequencer.sv
// Directed bench: table of per-cycle vectors plus hand sequences for underrun, saturation and reset.
module tb_serial_audio_frame_sequencer;

  logic        sclk = 1'b0;
  logic        reset, enable, zero_fill, clear_stats, s_valid, o_ready, enc_underrun;
  logic [15:0] s_left, s_right;
  logic        s_ready, o_valid, o_is_left, running;
  logic [15:0] o_data, underrun_count, zero_frame_count;
  logic        sat_s_ready, sat_o_valid, sat_o_is_left, sat_running;
  logic [15:0] sat_o_data;
  logic [3:0]  sat_urc, sat_zfc;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 sclk = ~sclk;

  serial_audio_frame_sequencer #(.data_width(16), .count_width(16)) dut (
    .sclk(sclk), .reset(reset), .enable(enable), .zero_fill(zero_fill),
    .clear_stats(clear_stats), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .o_valid(o_valid), .o_ready(o_ready),
    .o_is_left(o_is_left), .o_data(o_data), .enc_underrun(enc_underrun),
    .running(running), .underrun_count(underrun_count),
    .zero_frame_count(zero_frame_count)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  serial_audio_frame_sequencer #(.data_width(16), .count_width(4)) dut_sat (
    .sclk(sclk), .reset(reset), .enable(enable), .zero_fill(zero_fill),
    .clear_stats(clear_stats), .s_valid(s_valid), .s_ready(sat_s_ready),
    .s_left(s_left), .s_right(s_right), .o_valid(sat_o_valid), .o_ready(o_ready),
    .o_is_left(sat_o_is_left), .o_data(sat_o_data), .enc_underrun(enc_underrun),
    .running(sat_running), .underrun_count(sat_urc),
    .zero_frame_count(sat_zfc)
  );

  typedef struct {
    logic        e, z, sv;
    logic [15:0] l, r;
    logic        ordy;
    logic        exp_srdy, exp_ov, exp_il, chk_d;
    logic [15:0] exp_d;
    logic        exp_run;
    logic [15:0] exp_zfc;
  } vec_t;

  vec_t vecs [32];

  function automatic vec_t mk(input logic e, z, sv, input logic [15:0] l, r, input logic ordy,
                              input logic srdy, ov, il, chk, input logic [15:0] d,
                              input logic run, input logic [15:0] zfc);
    vec_t v;
    v.e = e; v.z = z; v.sv = sv; v.l = l; v.r = r; v.ordy = ordy;
    v.exp_srdy = srdy; v.exp_ov = ov; v.exp_il = il; v.chk_d = chk; v.exp_d = d;
    v.exp_run = run; v.exp_zfc = zfc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 1'b0, 1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 16'd0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 16'd0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hABCD, 1'b1, 16'd0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hABCD, 1'b1, 16'd0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'd0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0012, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 16'd0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0012, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0011, 1'b1, 16'd0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b1, 16'h0021, 16'h0022, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0012, 1'b1, 16'd0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b1, 16'h0021, 16'h0022, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0021, 1'b1, 16'd0);
    vecs[10] = mk(1'b1, 1'b0, 1'b1, 16'h0031, 16'h0032, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0022, 1'b1, 16'd0);
    vecs[11] = mk(1'b1, 1'b0, 1'b1, 16'h0031, 16'h0032, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0031, 1'b1, 16'd0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0032, 1'b1, 16'd0);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0);
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'd1);
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'd1);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'd2);
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'd2);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'd3);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'd3);
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 16'h0055, 16'h0066, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0055, 1'b1, 16'd3);
    vecs[21] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0066, 1'b1, 16'd3);
    vecs[22] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0066, 1'b1, 16'd3);
    vecs[23] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd3);
    vecs[24] = mk(1'b1, 1'b0, 1'b1, 16'h0A0A, 16'h0B0B, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0A0A, 1'b1, 16'd3);
    vecs[25] = mk(1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h0B0B, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0A0A, 1'b1, 16'd3);
    vecs[26] = mk(1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h0B0B, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0B0B, 1'b1, 16'd3);
    vecs[27] = mk(1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h0B0B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd3);
    vecs[28] = mk(1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h0B0B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd3);
    vecs[29] = mk(1'b1, 1'b0, 1'b1, 16'h0C0C, 16'h0D0D, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0C0C, 1'b1, 16'd3);
    vecs[30] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0D0D, 1'b1, 16'd3);
    vecs[31] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd3);

    reset = 1'b1; enable = 1'b0; zero_fill = 1'b0; clear_stats = 1'b0; s_valid = 1'b0;
    o_ready = 1'b0; enc_underrun = 1'b0; s_left = 16'h0000; s_right = 16'h0000;
    tick();
    tick();
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_is_left", o_is_left, 1'b1);
    chk("rst_o_data", o_data, 16'h0000);
    chk("rst_running", running, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_urc", underrun_count, 16'd0);
    chk("rst_zfc", zero_frame_count, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      enable = vecs[i].e; zero_fill = vecs[i].z; s_valid = vecs[i].sv;
      s_left = vecs[i].l; s_right = vecs[i].r; o_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_s_ready", i), s_ready, vecs[i].exp_srdy);
      tick();
      chk($sformatf("v%0d_o_valid", i), o_valid, vecs[i].exp_ov);
      chk($sformatf("v%0d_o_is_left", i), o_is_left, vecs[i].exp_il);
      if (vecs[i].chk_d) chk($sformatf("v%0d_o_data", i), o_data, vecs[i].exp_d);
      chk($sformatf("v%0d_running", i), running, vecs[i].exp_run);
      chk($sformatf("v%0d_zfc", i), zero_frame_count, vecs[i].exp_zfc);
      chk($sformatf("v%0d_urc", i), underrun_count, 16'd0);
    end

    // Hold a frame in LEFT so the block is running, then raise an underrun edge.
    enable = 1'b1; zero_fill = 1'b0; s_valid = 1'b1; s_left = 16'h0E0E; s_right = 16'h0F0F; o_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    enc_underrun = 1'b1; tick();
    chk("und_first_edge", underrun_count, 16'd1);
    enc_underrun = 1'b0; tick();
    enc_underrun = 1'b1; clear_stats = 1'b1; tick();
    chk("und_clear_wins", underrun_count, 16'd0);
    chk("zfc_cleared", zero_frame_count, 16'd0);
    enc_underrun = 1'b0; clear_stats = 1'b0; tick();
    for (int k = 0; k < 21; k++) begin
      enc_underrun = 1'b1; tick();
      enc_underrun = 1'b0; tick();
    end
    chk("und_21_edges", underrun_count, 16'd21);
    chk("und_saturated", sat_urc, 4'hF);
    chk("und_held_left", o_data, 16'h0E0E);
    clear_stats = 1'b1; tick();
    clear_stats = 1'b0;
    chk("sat_cleared", sat_urc, 4'h0);

    // Finish the frame; an underrun edge while idle must not count.
    o_ready = 1'b1; tick(); tick();
    chk("idle_after_drain", running, 1'b0);
    o_ready = 1'b0; enc_underrun = 1'b1; tick();
    chk("und_idle_ignored", underrun_count, 16'd0);
    enc_underrun = 1'b0; tick();

    // Reset while in RIGHT with a nonzero counter.
    s_valid = 1'b1; s_left = 16'h0E0E; s_right = 16'h0F0F; tick();
    s_valid = 1'b0; enc_underrun = 1'b1; tick();
    chk("pre_reset_urc", underrun_count, 16'd1);
    enc_underrun = 1'b0; o_ready = 1'b1; tick();
    chk("pre_reset_right", o_is_left, 1'b0);
    o_ready = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    chk("mid_rst_o_valid", o_valid, 1'b0);
    chk("mid_rst_running", running, 1'b0);
    chk("mid_rst_urc", underrun_count, 16'd0);
    chk("mid_rst_o_is_left", o_is_left, 1'b1);
    tick();
    chk("no_reissue", o_valid, 1'b0);
    s_valid = 1'b1; s_left = 16'h1111; s_right = 16'h2222; tick();
    s_valid = 1'b0;
    chk("restart_left", o_is_left, 1'b1);
    chk("restart_data", o_data, 16'h1111);
    chk("restart_valid", o_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
